// File: rtl/oversampling_period_measure.sv
// Sub-clock period meter: timestamps the first rising edge in each oversampled word, reports edge-to-edge delta.
// Optional OVERSAMPLING_PERIOD_MEASURE_SATURATE_EN: periods of 2^COUNTER_BITS-1 clocks or more report all ones.
module oversampling_period_measure #(
  parameter int unsigned COUNTER_BITS      = 16,
  parameter int unsigned OVERSAMPLING_BITS = 3
) (
  input  logic                                        CLK,
  input  logic                                        RESETN,
  input  logic [(1 << OVERSAMPLING_BITS)-1:0]         FREQ_IN,
  output logic                                        EDGE_FLAG,
  output logic [COUNTER_BITS+OVERSAMPLING_BITS-1:0]   DURATION
);

  localparam int unsigned N  = 1 << OVERSAMPLING_BITS;
  localparam int unsigned PW = (OVERSAMPLING_BITS == 0) ? 1 : OVERSAMPLING_BITS;
  localparam int unsigned CW = COUNTER_BITS;
  localparam int unsigned DW = COUNTER_BITS + OVERSAMPLING_BITS;

  logic [CW-1:0] counter_q, counter_d;
  logic          hist_q, hist_d;
  logic          edge_q, edge_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [CW-1:0] stamp_q, stamp_d;
  logic [DW-1:0] tprev_q, tprev_d;
  logic          tvalid_q, tvalid_d;
  logic [DW-1:0] dur_q, dur_d;
  logic          flag_q, flag_d;

  logic [N:0]    seq_c;
  logic          found_c;
  logic [PW-1:0] pos_c;
  logic [DW-1:0] ts_c;
  logic [DW-1:0] delta_c;

  // Earliest 0->1 transition in {word, history}; scanning downward lets the lowest index win.
  always_comb begin
    seq_c   = {FREQ_IN, hist_q};
    found_c = 1'b0;
    pos_c   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (seq_c[i+1] && !seq_c[i]) begin
        found_c = 1'b1;
        pos_c   = PW'(i);
      end
    end
  end

  assign ts_c    = (DW'(stamp_q) << OVERSAMPLING_BITS) | DW'(pos_q);
  assign delta_c = ts_c - tprev_q;

`ifdef OVERSAMPLING_PERIOD_MEASURE_SATURATE_EN
  logic [CW-1:0] since_q, since_d;
  logic          ovf_c;

  // Whole clocks since the reference edge was captured, sticking at all ones.
  always_comb begin
    since_d = since_q;
    if (edge_q) begin
      since_d = CW'(1);
    end else if (since_q != {CW{1'b1}}) begin
      since_d = since_q + CW'(1);
    end
  end

  assign ovf_c = (since_q == {CW{1'b1}});

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      since_q <= '0;
    end else begin
      since_q <= since_d;
    end
  end
`endif

  always_comb begin
    counter_d = counter_q + CW'(1);
    hist_d    = FREQ_IN[N-1];
    edge_d    = found_c;
    pos_d     = pos_c;
    stamp_d   = counter_q;
    tprev_d   = tprev_q;
    tvalid_d  = tvalid_q;
    dur_d     = dur_q;
    flag_d    = 1'b0;
    if (edge_q) begin
      if (tvalid_q) begin
`ifdef OVERSAMPLING_PERIOD_MEASURE_SATURATE_EN
        dur_d = ovf_c ? {DW{1'b1}} : delta_c;
`else
        dur_d = delta_c;
`endif
        flag_d = 1'b1;
      end
      tprev_d  = ts_c;
      tvalid_d = 1'b1;
    end
  end

  // History resets high so a line already high at release is not an edge.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      counter_q <= '0;
      hist_q    <= 1'b1;
      edge_q    <= 1'b0;
      pos_q     <= '0;
      stamp_q   <= '0;
      tprev_q   <= '0;
      tvalid_q  <= 1'b0;
      dur_q     <= '0;
      flag_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      hist_q    <= hist_d;
      edge_q    <= edge_d;
      pos_q     <= pos_d;
      stamp_q   <= stamp_d;
      tprev_q   <= tprev_d;
      tvalid_q  <= tvalid_d;
      dur_q     <= dur_d;
      flag_q    <= flag_d;
    end
  end

  assign EDGE_FLAG = flag_q;
  assign DURATION  = dur_q;

endmodule

// File: tb/tb_oversampling_period_measure.sv
// Directed bench for oversampling_period_measure (COUNTER_BITS=16, x8 oversampling).
module tb_oversampling_period_measure;

  logic        CLK;
  logic        RESETN;
  logic [7:0]  FREQ_IN;
  logic        EDGE_FLAG;
  logic [18:0] DURATION;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  oversampling_period_measure #(
    .COUNTER_BITS(16),
    .OVERSAMPLING_BITS(3)
  ) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .FREQ_IN(FREQ_IN),
    .EDGE_FLAG(EDGE_FLAG),
    .DURATION(DURATION)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One word per clock; word presented before posedge k is timestamped with counter k.
  task automatic step(input logic [7:0] w);
    FREQ_IN = w;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input logic [7:0] w);
    FREQ_IN = w;
    RESETN  = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RESETN = 1'b1;
    cyc    = 0;
  endtask

  // n clocks: edge word, high fill for about half, low for the rest.
  task automatic period(input logic [7:0] ew, input logic [7:0] hi, input int n,
                        input bit expf, input int expd, input string tag);
    step(ew);
    step(hi);
    chk({tag, "_flag"}, 32'(EDGE_FLAG), 32'(expf));
    if (expf) chk({tag, "_dur"}, 32'(DURATION), 32'(expd));
    step(hi);
    chk({tag, "_pulse"}, 32'(EDGE_FLAG), 32'd0);
    for (int i = 0; i < n / 2 - 3; i++) step(hi);
    for (int i = 0; i < n - n / 2; i++) step(8'h00);
  endtask

  initial begin
    logic [7:0] w;
    longint     s, ph, thr, ref_s, es, pdur;
    bit         have_ref, pend, hist, prevb;

    RESETN  = 1'b0;
    FREQ_IN = 8'h00;
    @(posedge CLK);
    #1;
    chk("reset_flag", 32'(EDGE_FLAG), 32'd0);
    chk("reset_dur", 32'(DURATION), 32'd0);
    @(negedge CLK);
    RESETN = 1'b1;
    cyc    = 0;

    for (int i = 0; i < 4; i++) step(8'h00);
    period(8'hF8, 8'hFF, 40, 1'b0, 0,   "p3_first");
    period(8'hF8, 8'hFF, 40, 1'b1, 320, "p3_a");
    period(8'hF8, 8'hFF, 40, 1'b1, 320, "p3_b");
    period(8'hF8, 8'hFF, 40, 1'b1, 320, "p3_c");
    period(8'hE0, 8'hFF, 40, 1'b1, 322, "p5");
    period(8'hFF, 8'hFF, 40, 1'b1, 315, "p0");
    period(8'h54, 8'h00, 50, 1'b1, 322, "multi_a");
    period(8'h54, 8'h00, 40, 1'b1, 400, "multi_b");

    // Reset with a captured-but-unreported edge in flight and the line high.
    step(8'hFF);
    RESETN = 1'b0;
    #1;
    chk("midrst_flag", 32'(EDGE_FLAG), 32'd0);
    chk("midrst_dur", 32'(DURATION), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    RESETN = 1'b1;
    cyc    = 0;
    for (int i = 0; i < 3; i++) begin
      step(8'hFF);
      chk("rel_high_flag", 32'(EDGE_FLAG), 32'd0);
    end
    for (int i = 0; i < 5; i++) step(8'h00);
    period(8'hF8, 8'hFF, 40, 1'b0, 0,   "rst_first");
    period(8'hF8, 8'hFF, 40, 1'b1, 320, "rst_second");

    // 4290.46 ns square wave: sub-sample 1.25 ns = 125 units of 10 ps, period 429046 units.
    do_reset(8'h00);
    have_ref = 1'b0;
    pend     = 1'b0;
    pdur     = 0;
    ref_s    = 0;
    hist     = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      thr = (c < 3000) ? 64'd214523 : 64'd107262;
      es  = -1;
      prevb = hist;
      for (int i = 0; i < 8; i++) begin
        s    = longint'(cyc) * 8 + i;
        ph   = (s * 125) % 429046;
        w[i] = (ph < thr);
        if (w[i] && !prevb && es < 0) es = s;
        prevb = w[i];
      end
      hist = w[7];
      step(w);
      chk("sq_flag", 32'(EDGE_FLAG), 32'(pend));
      if (pend) begin
        chk("sq_dur", 32'(DURATION), 32'(pdur));
        chk("sq_range", 32'((DURATION == 19'h00D68) || (DURATION == 19'h00D69)), 32'd1);
      end
      pend = 1'b0;
      if (es >= 0) begin
        if (have_ref) begin
          pend = 1'b1;
          pdur = es - ref_s;
        end
        ref_s    = es;
        have_ref = 1'b1;
      end
    end

    // Edges at counter 0xFFA8, 0xFFD0 and 0x0034 (after wrap), all at p=1.
    do_reset(8'h00);
    while (cyc < 32'hFFD0 - 40) step(8'h00);
    period(8'hFE, 8'hFF, 40,  1'b0, 0,   "wrap_ref");
    period(8'hFE, 8'hFF, 100, 1'b1, 320, "wrap_pre");
    period(8'hFE, 8'hFF, 40,  1'b1, 800, "wrap_cross");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
